// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit (radix-2 shift-add
// multiplier, restoring divider) with sign fix-up. Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    c_last  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_min   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [4:0] c_op_mul    = 5'b01001;
  localparam logic [4:0] c_op_mulh   = 5'b01010;
  localparam logic [4:0] c_op_mulhu  = 5'b01011;
  localparam logic [4:0] c_op_mulhsu = 5'b01100;
  localparam logic [4:0] c_op_div    = 5'b01101;
  localparam logic [4:0] c_op_divu   = 5'b01110;
  localparam logic [4:0] c_op_rem    = 5'b01111;
  localparam logic [4:0] c_op_remu   = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t r_state, w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic             r_div, r_want_hi, r_want_rem, r_special, r_neg_q, r_neg_r;

  logic             w_is_m, w_div, w_sign_a, w_sign_b, w_want_hi, w_want_rem;
  logic             w_neg_a, w_neg_b, w_special, w_accept;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_special_val, w_fix_result;
  logic [WIDTH:0]   w_sum, w_trial;
  logic [2*WIDTH-1:0] w_prod;

  always_comb begin
    w_is_m     = 1'b0;
    w_div      = 1'b0;
    w_sign_a   = 1'b0;
    w_sign_b   = 1'b0;
    w_want_hi  = 1'b0;
    w_want_rem = 1'b0;
    case (aluop)
      c_op_mul:    w_is_m = 1'b1;
      c_op_mulh:   begin w_is_m = 1'b1; w_sign_a = 1'b1; w_sign_b = 1'b1; w_want_hi = 1'b1; end
      c_op_mulhsu: begin w_is_m = 1'b1; w_sign_a = 1'b1; w_want_hi = 1'b1; end
      c_op_mulhu:  begin w_is_m = 1'b1; w_want_hi = 1'b1; end
      c_op_div:    begin w_is_m = 1'b1; w_div = 1'b1; w_sign_a = 1'b1; w_sign_b = 1'b1; end
      c_op_divu:   begin w_is_m = 1'b1; w_div = 1'b1; end
      c_op_rem:    begin w_is_m = 1'b1; w_div = 1'b1; w_sign_a = 1'b1; w_sign_b = 1'b1;
                         w_want_rem = 1'b1; end
      c_op_remu:   begin w_is_m = 1'b1; w_div = 1'b1; w_want_rem = 1'b1; end
      default: ;
    endcase
  end

  assign w_neg_a = w_sign_a & op1[WIDTH-1];
  assign w_neg_b = w_sign_b & op2[WIDTH-1];
  assign w_mag_a = w_neg_a ? -op1 : op1;
  assign w_mag_b = w_neg_b ? -op2 : op2;

  // Divide-by-zero and signed overflow bypass iteration; the answer is known now.
  always_comb begin
    w_special     = 1'b0;
    w_special_val = '0;
    if (w_div && (op2 == '0)) begin
      w_special     = 1'b1;
      w_special_val = w_want_rem ? op1 : '1;
    end else if (w_div && w_sign_a && (op1 == c_min) && (op2 == '1)) begin
      w_special     = 1'b1;
      w_special_val = w_want_rem ? '0 : c_min;
    end
  end

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start && w_is_m && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = w_special ? S_FIX : S_CALC;
        else          w_next = S_IDLE;
      end
      S_CALC: begin
        if (flush)                w_next = S_IDLE;
        else if (r_cnt == c_last) w_next = S_FIX;
      end
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_hi/r_lo form the product (high/low) or remainder/quotient-shift pair.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
  assign w_prod  = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};

  always_comb begin
    if (r_special)       w_fix_result = r_lo;
    else if (!r_div)     w_fix_result = r_want_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
    else if (r_want_rem) w_fix_result = r_neg_r ? -r_hi : r_hi;
    else                 w_fix_result = r_neg_q ? -r_lo : r_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_b        <= '0;
      r_div      <= 1'b0;
      r_want_hi  <= 1'b0;
      r_want_rem <= 1'b0;
      r_special  <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      result     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt      <= '0;
        r_div      <= w_div;
        r_want_hi  <= w_want_hi;
        r_want_rem <= w_want_rem;
        r_special  <= w_special;
        r_neg_q    <= w_neg_a ^ w_neg_b;
        r_neg_r    <= w_neg_a;
        r_hi       <= '0;
        if (w_special) begin
          r_lo <= w_special_val;
          r_b  <= '0;
        end else if (w_div) begin
          r_lo <= w_mag_a;
          r_b  <= w_mag_b;
        end else begin
          r_lo <= w_mag_b;
          r_b  <= w_mag_a;
        end
      end else if ((r_state == S_CALC) && !flush) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_div) begin
          if (!w_trial[WIDTH]) begin
            r_hi <= w_trial[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
        end
      end
      if ((r_state == S_FIX) && !flush) result <= w_fix_result;
    end
  end

  assign busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) selected by the control unit's 5-bit ALUOP encoding.
- Accepts one operation at a time, iterates a radix-2 shift-add multiplier or restoring divider over WIDTH cycles, and applies sign correction.
- Holds the pipeline via BUSY and returns RESULT with a one-cycle DONE pulse.
- Sits beside the single-cycle ALU in the EX stage.

Parameters:
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE or DONE.
- ALUOP  input  5  op select: 01001 MUL, 01010 MULH, 01100 MULHSU, 01011 MULHU, 01101 DIV, 01110 DIVU, 01111 REM, 10000 REMU.
- OP1  input  WIDTH  rs1 value (multiplicand/dividend).
- OP2  input  WIDTH  rs2 value (multiplier/divisor).
- FLUSH  input  1  abort the in-flight operation (branch/jump squash).
- BUSY  output  1  stall request to the pipeline.
- DONE  output  1  one-cycle pulse; RESULT valid.
- RESULT  output  WIDTH  operation result; held until the next accepted START.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; BUSY=0, DONE=0, RESULT=0; counter, accumulators and latched op cleared.
- States: IDLE, CALC, FIX, DONE.
- Accept: START=1, ALUOP is one of the 8 M codes, and state is IDLE or DONE. The edge latches OP1, OP2, ALUOP, takes operand magnitudes per signedness, and records the result sign.
  - Signed operands: MULH both, MULHSU OP1 only, DIV/REM both, MUL treated as unsigned (low word identical).
- START with a non-M ALUOP is ignored: state unchanged, BUSY stays 0.
- START in CALC or FIX is ignored; the latched operands are unaffected.
- IDLE/DONE -> CALC on a normal accept; counter=0.
- IDLE/DONE -> FIX directly, with no iteration, for the special cases:
  - divisor==0: DIV/DIVU give all-ones; REM/REMU give OP1.
  - signed overflow (DIV/REM with OP1=0x80000000, OP2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle; counter increments. After the WIDTH-th iteration (counter==WIDTH-1) -> FIX.
  - Multiply: 2*WIDTH-bit product of magnitudes.
  - Divide: restoring; quotient and remainder of magnitudes.
- FIX: negate the result if required, select the result word, register RESULT; -> DONE.
  - Multiply: negate the product if the sign flag is set. MUL selects the low word; MULH/MULHSU/MULHU select the high word.
  - Divide: quotient sign = sign(OP1) XOR sign(OP2); remainder sign = sign(OP1).
- DONE: DONE=1 for exactly one cycle. Goes to CALC/FIX if a new START is accepted this cycle, else IDLE.
- BUSY:
  - High from the cycle after the accept edge through FIX inclusive.
  - Low in IDLE and DONE.
  - Never high in the same cycle as DONE.
- Latency, START sampled at edge N:
  - Normal operation: BUSY high after edges N..N+WIDTH+0 (CALC WIDTH cycles, then FIX); DONE high after edge N+WIDTH+1, i.e. 34 cycles for WIDTH=32.
  - Special case: FIX after N, DONE after N+1.
- FLUSH=1 at any edge in CALC or FIX: -> IDLE, BUSY=0, no DONE pulse, RESULT unchanged.
  - FLUSH in IDLE/DONE: clears DONE to IDLE.
  - FLUSH takes priority over a simultaneous START.
- Reset asserted mid-operation: immediate return to the reset values; no DONE.
- Arithmetic is modulo 2^WIDTH; negation is two's complement. Negating 0x80000000 yields 0x80000000 and is not flagged.

Test Plan:
- MUL OP1=7, OP2=0xFFFFFFFD (-3), START at edge N: BUSY high for 33 cycles; DONE pulses one cycle after edge N+33; RESULT=0xFFFFFFEB; BUSY=0 during DONE.
- High-word multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MUL 0x10000 x 0x10000 -> 0x00000000.
- Divide/remainder:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002.
  - DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 0x00000001.
- Special cases, each with DONE one cycle after edge N+1 and no CALC cycles:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Abort and reset:
  - FLUSH asserted on the 10th CALC cycle: BUSY=0 next cycle, DONE never pulses, RESULT keeps its prior value.
  - RESET pulled low mid-CALC: BUSY/DONE/RESULT go to 0 without waiting for a clock.
- Request handling:
  - START with ALUOP=00001 (ADD): no BUSY, no DONE.
  - START mid-CALC with different operands: ignored; the original result is returned.
  - START asserted in the DONE cycle: accepted; the second result follows 34 cycles later.
